// File: rtl/nibble_packer.sv
// nibble_packer: pairs consecutive valid nibbles into bytes (first nibble in
// the high half) and buffers them in a first-word fall-through FIFO. Also
// keeps a saturating count of qualified flags and a sticky drop indicator.
//
// Output handshake: byte_valid is high exactly when the FIFO holds at least
// one byte, and byte_out then shows the oldest byte. A byte is consumed on a
// rising edge where byte_valid and byte_ready are both high. byte_ready while
// byte_valid is low is ignored. byte_valid never depends on byte_ready.
// The input side has no backpressure: every nib_valid cycle is taken.
module nibble_packer #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [3:0]               nib_in,
  input  logic                     nib_valid,
  input  logic                     flag_in,
  output logic [7:0]               byte_out,
  output logic                     byte_valid,
  input  logic                     byte_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     half,
  output logic [CNT_W-1:0]         flag_count,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

  // Pairing state: whether a first nibble is waiting for its partner.
  // It is exported directly as the half output.
  typedef enum logic {
    HOLD_EMPTY = 1'b0,
    HOLD_FULL  = 1'b1
  } hold_state_t;

  hold_state_t      hold_state;
  logic [3:0]       hold_nib;
  logic [7:0]       mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    count;
  logic [CNT_W-1:0] flag_cnt;
  logic             ovf;

  logic             pop;
  logic             push_req;
  logic             push;
  logic             drop;
  logic             full;
  logic [7:0]       new_byte;

  // Handshake and push/drop decisions; a full FIFO still accepts a byte
  // when the head leaves on the same edge.
  always_comb begin
    byte_valid = (count != '0);
    byte_out   = byte_valid ? mem[rd_ptr] : 8'h00;
    level      = count;
    half       = (hold_state == HOLD_FULL);
    flag_count = flag_cnt;
    overflow   = ovf;
    full       = (count == DEPTH_L);
    pop        = byte_valid & byte_ready;
    push_req   = nib_valid & (hold_state == HOLD_FULL);
    push       = push_req & (~full | pop);
    drop       = push_req & full & ~pop;
    new_byte   = {hold_nib, nib_in};
  end

  // Pairing FSM: toggles on every valid nibble, whether or not the byte fits.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_state <= HOLD_EMPTY;
      hold_nib   <= 4'h0;
    end else if (nib_valid) begin
      case (hold_state)
        HOLD_EMPTY: begin
          hold_nib   <= nib_in;
          hold_state <= HOLD_FULL;
        end
        HOLD_FULL: begin
          hold_state <= HOLD_EMPTY;
        end
        default: hold_state <= HOLD_EMPTY;
      endcase
    end
  end

  // Saturating flag counter, independent of pairing and FIFO state.
  always_ff @(posedge clk) begin
    if (rst) begin
      flag_cnt <= '0;
    end else if (nib_valid && flag_in && (flag_cnt != '1)) begin
      flag_cnt <= flag_cnt + 1'b1;
    end
  end

  // FIFO storage, pointers (wrap naturally at DEPTH) and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= 8'h00;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= new_byte;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky record of any completed byte lost to a full FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (drop) begin
      ovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_nibble_packer.sv
// Bench for nibble_packer: table-driven vectors plus hand-written corner
// sequences, with a reference queue of expected bytes checked at the output.
module tb_nibble_packer;

  localparam int DEPTH = 4;
  localparam int CNT_W = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  // ---------------- clock / reset / DUT ----------------
  logic                   clk;
  logic                   rst;
  logic [3:0]             nib_in;
  logic                   nib_valid;
  logic                   flag_in;
  logic [7:0]             byte_out;
  logic                   byte_valid;
  logic                   byte_ready;
  logic [$clog2(DEPTH):0] level;
  logic                   half;
  logic [CNT_W-1:0]       flag_count;
  logic                   overflow;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  nibble_packer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .nib_in     (nib_in),
    .nib_valid  (nib_valid),
    .flag_in    (flag_in),
    .byte_out   (byte_out),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .level      (level),
    .half       (half),
    .flag_count (flag_count),
    .overflow   (overflow)
  );

  // ---------------- scoreboard / reference model ----------------
  logic [7:0] exp_q[$];
  logic       m_half;
  logic [3:0] m_hold;
  logic       m_ovf;
  int         m_cnt;
  int         n_cmp;
  int         n_fail;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    m_half = 1'b0;
    m_hold = 4'h0;
    m_ovf  = 1'b0;
    m_cnt  = 0;
  endtask

  // Reset with every other input active, to show rst wins.
  task automatic do_reset();
    rst        = 1'b1;
    nib_valid  = 1'b1;
    nib_in     = 4'h7;
    flag_in    = 1'b1;
    byte_ready = 1'b1;
    @(posedge clk);
    #1;
    rst       = 1'b0;
    nib_valid = 1'b0;
    flag_in   = 1'b0;
    byte_ready = 1'b0;
    model_clear();
    check("rst_level", level, 0);
    check("rst_valid", byte_valid, 0);
    check("rst_byte", byte_out, 0);
    check("rst_half", half, 0);
    check("rst_flag_count", flag_count, 0);
    check("rst_overflow", overflow, 0);
  endtask

  // One clock: drive inputs, check the head byte before the edge against the
  // expected queue, advance the model, then check registered state after it.
  task automatic cycle(input logic nv, input logic [3:0] nib, input logic fl, input logic rdy);
    int         sz;
    logic       do_pop;
    logic [7:0] b;
    nib_valid  = nv;
    nib_in     = nib;
    flag_in    = fl;
    byte_ready = rdy;
    #1;
    sz = exp_q.size();
    check("byte_valid", byte_valid, (sz != 0));
    check("byte_out", byte_out, (sz != 0) ? exp_q[0] : 8'h00);
    do_pop = (sz != 0) && rdy;
    if (do_pop) void'(exp_q.pop_front());
    if (nv) begin
      if (m_half) begin
        b = {m_hold, nib};
        if ((sz < DEPTH) || do_pop) exp_q.push_back(b);
        else m_ovf = 1'b1;
        m_half = 1'b0;
      end else begin
        m_hold = nib;
        m_half = 1'b1;
      end
      if (fl && (m_cnt < CNT_MAX)) m_cnt++;
    end
    @(posedge clk);
    #1;
    check("level", level, exp_q.size());
    check("half", half, m_half);
    check("overflow", overflow, m_ovf);
    check("flag_count", flag_count, m_cnt);
  endtask

  // ---------------- table-driven vectors ----------------
  typedef struct {
    logic       nv;
    logic [3:0] nib;
    logic       rdy;
    logic [7:0] exp_byte;
    logic       exp_valid;
    int         exp_level;
    logic       exp_half;
  } vec_t;

  vec_t vecs[10];

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    rst = 1'b1; nib_valid = 1'b0; nib_in = 4'h0; flag_in = 1'b0; byte_ready = 1'b0;
    model_clear();

    // pair 0xA,0x5, then drain; then 0xF, three idle cycles, 0x0
    vecs[0] = '{1'b1, 4'hA, 1'b0, 8'h00, 1'b0, 0, 1'b1};
    vecs[1] = '{1'b1, 4'h5, 1'b0, 8'hA5, 1'b1, 1, 1'b0};
    vecs[2] = '{1'b0, 4'h0, 1'b0, 8'hA5, 1'b1, 1, 1'b0};
    vecs[3] = '{1'b0, 4'h0, 1'b1, 8'h00, 1'b0, 0, 1'b0};
    vecs[4] = '{1'b1, 4'hF, 1'b0, 8'h00, 1'b0, 0, 1'b1};
    vecs[5] = '{1'b0, 4'h0, 1'b0, 8'h00, 1'b0, 0, 1'b1};
    vecs[6] = '{1'b0, 4'h0, 1'b1, 8'h00, 1'b0, 0, 1'b1};
    vecs[7] = '{1'b0, 4'h0, 1'b0, 8'h00, 1'b0, 0, 1'b1};
    vecs[8] = '{1'b1, 4'h0, 1'b0, 8'hF0, 1'b1, 1, 1'b0};
    vecs[9] = '{1'b0, 4'h0, 1'b1, 8'h00, 1'b0, 0, 1'b0};

    @(posedge clk);
    #1;
    do_reset();

    for (int i = 0; i < 10; i++) begin
      cycle(vecs[i].nv, vecs[i].nib, 1'b0, vecs[i].rdy);
      check("vec_byte", byte_out, vecs[i].exp_byte);
      check("vec_valid", byte_valid, vecs[i].exp_valid);
      check("vec_level", level, vecs[i].exp_level);
      check("vec_half", half, vecs[i].exp_half);
    end

    // Fill FIFO with 0x12,0x34,0x56,0x78, then overflow with 0x9A.
    do_reset();
    for (int n = 1; n <= 8; n++) cycle(1'b1, 4'(n), 1'b0, 1'b0);
    check("full_level", level, 4);
    check("full_head", byte_out, 8'h12);
    cycle(1'b1, 4'h9, 1'b0, 1'b0);
    cycle(1'b1, 4'hA, 1'b0, 1'b0);
    check("drop_overflow", overflow, 1);
    check("drop_level", level, 4);
    check("drop_half", half, 0);
    for (int n = 0; n < 4; n++) cycle(1'b0, 4'h0, 1'b0, 1'b1);
    check("drained_valid", byte_valid, 0);
    check("drained_byte", byte_out, 8'h00);
    check("drained_overflow", overflow, 1);

    // Full FIFO, pop on the same edge as the completing nibble.
    do_reset();
    for (int n = 1; n <= 8; n++) cycle(1'b1, 4'(n), 1'b0, 1'b0);
    cycle(1'b1, 4'hB, 1'b0, 1'b0);
    cycle(1'b1, 4'hC, 1'b0, 1'b1);
    check("pushpop_level", level, 4);
    check("pushpop_overflow", overflow, 0);
    check("pushpop_head", byte_out, 8'h34);
    for (int n = 0; n < 4; n++) cycle(1'b0, 4'h0, 1'b0, 1'b1);
    check("pushpop_empty", byte_valid, 0);

    // Flag counter: ignored without nib_valid, then saturates.
    do_reset();
    for (int n = 0; n < 3; n++) cycle(1'b0, 4'h0, 1'b1, 1'b0);
    check("flag_unqualified", flag_count, 0);
    cycle(1'b1, 4'h1, 1'b1, 1'b1);
    check("flag_first", flag_count, 1);
    for (int n = 0; n < 300; n++) cycle(1'b1, 4'($urandom_range(0, 15)), 1'b1, 1'b1);
    check("flag_saturated", flag_count, 255);
    for (int n = 0; n < 3; n++) cycle(1'b0, 4'h0, 1'b1, 1'b1);
    check("flag_hold", flag_count, 255);

    // Reset mid-operation discards a held nibble and buffered bytes.
    do_reset();
    cycle(1'b1, 4'h1, 1'b1, 1'b0);
    cycle(1'b1, 4'h1, 1'b0, 1'b0);
    cycle(1'b1, 4'h2, 1'b0, 1'b0);
    cycle(1'b1, 4'h2, 1'b0, 1'b0);
    cycle(1'b1, 4'h3, 1'b0, 1'b0);
    check("pre_rst_level", level, 2);
    check("pre_rst_half", half, 1);
    do_reset();
    cycle(1'b1, 4'h4, 1'b0, 1'b0);
    cycle(1'b1, 4'h5, 1'b0, 1'b0);
    check("post_rst_byte", byte_out, 8'h45);
    check("post_rst_level", level, 1);

    // Random traffic against the reference queue.
    for (int n = 0; n < 300; n++) begin
      cycle(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
    end
    for (int n = 0; n < 6; n++) cycle(1'b0, 4'h0, 1'b0, 1'b1);
    check("final_empty", byte_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
